// File: rtl/serializer_pkg.sv
// -----------------------------------------------------------------------------
// serializer_pkg
//
// Purpose:
//   Shared types and constants for the bit_serializer parallel-to-serial stage.
//
// Contents:
//   state_t   - FSM state encoding (IDLE, SHIFT, PARITY, GAP)
//   GAP_CNT_W - width of the inter-frame gap counter
//
// Configuration:
//   The PARITY state is always declared here so the encoding stays stable.
//   The logic that uses it is only built when SERIALIZER_PARITY_EN is defined.
// -----------------------------------------------------------------------------
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam int GAP_CNT_W = 8;

endpackage : serializer_pkg

// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//
// Purpose:
//   Parallel-to-serial stage that feeds the serial sequence-detector FSMs.
//   It takes one DATA_W-bit word per valid/ready handshake and sends it out
//   one bit per clock on ser_bit. It is a Moore machine, so every output is
//   decoded from registered state only.
//
// Parameters:
//   DATA_W     - word width in bits (>= 2)
//   LSB_FIRST  - 0: bit DATA_W-1 is sent first, 1: bit 0 is sent first
//   GAP_CYCLES - idle bit-times inserted after each frame (0..255)
//
// Ports:
//   clk        in   clock, all logic on the rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   in_data holds a word
//   in_data    in   word to serialize (DATA_W bits)
//   in_ready   out  block can accept a word this cycle (IDLE only)
//   ser_bit    out  serial data bit, idles low outside frame bits
//   ser_valid  out  ser_bit carries a frame bit this cycle
//   frame_done out  high only during the final ser_valid cycle of a frame
//   busy       out  FSM not in IDLE
//
// Configuration:
//   SERIALIZER_PARITY_EN - when defined, each frame ends with one extra
//                          even-parity bit (XOR of the latched word).
// -----------------------------------------------------------------------------
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LSB_FIRST  = 0,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ser_bit,
  output logic              ser_valid,
  output logic              frame_done,
  output logic              busy
);

  localparam int CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int HEAD_IDX = (LSB_FIRST != 0) ? 0 : DATA_W - 1;

  // The gap counter is loaded with GAP_CYCLES-1 and counts down to zero, so
  // the GAP state lasts exactly GAP_CYCLES cycles. If there is no gap, GAP
  // is never entered and the load value does not matter.
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? GAP_CNT_W'(GAP_CYCLES - 1) : '0;

  // State that follows the last frame bit.
  localparam state_t POST_FRAME = (GAP_CYCLES > 0) ? GAP : IDLE;

`ifdef SERIALIZER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  state_t               state_q,   state_d;
  logic [DATA_W-1:0]    shift_q,   shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
`ifdef SERIALIZER_PARITY_EN
  logic                 parity_q,  parity_d;
`endif

  // State and datapath registers. Reset is synchronous and active-low.
  // A reset in the middle of a frame drops the word being sent; nothing is
  // flushed, and the line goes back to idle on the next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
`ifdef SERIALIZER_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
`ifdef SERIALIZER_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Next-state logic. Outputs are decoded from registered state only.
  //
  // IDLE latches a word on the handshake. SHIFT moves the next bit to the head
  // each cycle, and bit_cnt counts down to the last bit. The parity bit is
  // worked out when the word is latched, because the shift register is
  // changed as the frame is sent.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
`ifdef SERIALIZER_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d   = in_data;
          bit_cnt_d = CNT_W'(DATA_W - 1);
`ifdef SERIALIZER_PARITY_EN
          parity_d  = ^in_data;
`endif
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        shift_d = (LSB_FIRST != 0) ? (shift_q >> 1) : (shift_q << 1);
        if (bit_cnt_q == '0) begin
`ifdef SERIALIZER_PARITY_EN
          state_d   = PARITY;
`else
          state_d   = POST_FRAME;
          gap_cnt_d = GAP_LOAD;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end
      end

      PARITY: begin
`ifdef SERIALIZER_PARITY_EN
        state_d   = POST_FRAME;
        gap_cnt_d = GAP_LOAD;
`else
        state_d   = IDLE;
`endif
      end

      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode. The line stays low outside frame bits, so idle and gap
  // time never look like a run of ones to the detector downstream.
  // frame_done marks the last ser_valid cycle: the parity bit when parity is
  // built in, otherwise the last data bit.
  always_comb begin
    in_ready   = (state_q == IDLE);
    busy       = (state_q != IDLE);
    ser_valid  = 1'b0;
    ser_bit    = 1'b0;
    frame_done = 1'b0;

    case (state_q)
      SHIFT: begin
        ser_valid  = 1'b1;
        ser_bit    = shift_q[HEAD_IDX];
        frame_done = !PAR_EN && (bit_cnt_q == '0);
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        ser_valid  = 1'b1;
        ser_bit    = parity_q;
        frame_done = 1'b1;
      end
`endif
      default: begin
        ser_valid  = 1'b0;
      end
    endcase
  end

endmodule : bit_serializer

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer
//
// Purpose:
//   Directed self-checking bench for bit_serializer. Three instances share
//   clk and rst_n:
//     dut0 - MSB first, no gap
//     dut1 - LSB first, no gap
//     dut2 - MSB first, three gap cycles
//   Expected bit sequences are written out by hand for each word.
//
// Configuration:
//   SERIALIZER_PARITY_EN - when defined, every frame carries a ninth parity
//                          bit, and the bench checks that bit as well.
// -----------------------------------------------------------------------------
module tb_bit_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk;
  logic rst_n;

  logic       v0, v1, v2;
  logic [7:0] d0, d1, d2;
  logic       rdy0, bit0, sv0, done0, busy0;
  logic       rdy1, bit1, sv1, done1, busy1;
  logic       rdy2, bit2, sv2, done2, busy2;

  int vectors;
  int miscompares;

  bit_serializer #(.DATA_W(8), .LSB_FIRST(0), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_data(d0),
    .in_ready(rdy0), .ser_bit(bit0), .ser_valid(sv0),
    .frame_done(done0), .busy(busy0)
  );

  bit_serializer #(.DATA_W(8), .LSB_FIRST(1), .GAP_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_data(d1),
    .in_ready(rdy1), .ser_bit(bit1), .ser_valid(sv1),
    .frame_done(done1), .busy(busy1)
  );

  bit_serializer #(.DATA_W(8), .LSB_FIRST(0), .GAP_CYCLES(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_data(d2),
    .in_ready(rdy2), .ser_bit(bit2), .ser_valid(sv2),
    .frame_done(done2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move to just after the next rising edge. Inputs are driven and outputs
  // are sampled here, away from the edge itself.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one instance's handshake inputs.
  task automatic applyStimulus(input int d, input logic v, input logic [7:0] w);
    case (d)
      0:       begin v0 = v; d0 = w; end
      1:       begin v1 = v; d1 = w; end
      default: begin v2 = v; d2 = w; end
    endcase
  endtask

  // Returns {in_ready, ser_bit, ser_valid, frame_done, busy} of one instance.
  function automatic logic [4:0] sampleOut(input int d);
    case (d)
      0:       return {rdy0, bit0, sv0, done0, busy0};
      1:       return {rdy1, bit1, sv1, done1, busy1};
      default: return {rdy2, bit2, sv2, done2, busy2};
    endcase
  endfunction

  function automatic int gapOf(input int d);
    return (d == 2) ? 3 : 0;
  endfunction

  // Compare one observed value against the expected value.
  task automatic checkOutput(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed={rdy,bit,vld,done,busy}=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Handshake one word into the selected instance and check the whole frame.
  // expSeq lists the bits in wire order, first bit in expSeq[7].
  task automatic runFrame(input int d, input logic [7:0] word, input logic [7:0] expSeq,
                          input logic expPar, input string tag);
    applyStimulus(d, 1'b1, word);
    checkOutput({tag, "_accept"}, sampleOut(d), 5'b1_0_0_0_0);
    tick();
    applyStimulus(d, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("%s_bit%0d", tag, i), sampleOut(d),
                  {1'b0, expSeq[7-i], 1'b1, (i == 7 && P == 0), 1'b1});
      tick();
    end
    if (P == 1) begin
      checkOutput({tag, "_parity"}, sampleOut(d), {1'b0, expPar, 1'b1, 1'b1, 1'b1});
      tick();
    end
    for (int g = 0; g < gapOf(d); g++) begin
      checkOutput($sformatf("%s_gap%0d", tag, g), sampleOut(d), 5'b0_0_0_0_1);
      tick();
    end
    checkOutput({tag, "_idle"}, sampleOut(d), 5'b1_0_0_0_0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    d0 = 8'h00; d1 = 8'h00; d2 = 8'h00;

    // Reset held for two clocks: ready, line low, nothing valid, not busy.
    tick();
    tick();
    for (int d = 0; d < 3; d++)
      checkOutput($sformatf("reset_dut%0d", d), sampleOut(d), 5'b1_0_0_0_0);
    rst_n = 1'b1;
    tick();

    // MSB first: C0 gives 1,1,0,0,0,0,0,0 (parity 0).
    runFrame(0, 8'hC0, 8'b1100_0000, 1'b0, "msb_c0");
    // MSB first: A5 gives 1,0,1,0,0,1,0,1 (parity 0).
    runFrame(0, 8'hA5, 8'b1010_0101, 1'b0, "msb_a5");
    // MSB first: 07 gives 0,0,0,0,0,1,1,1 (parity 1).
    runFrame(0, 8'h07, 8'b0000_0111, 1'b1, "msb_07");
    // LSB first: 03 gives 1,1,0,0,0,0,0,0 (parity 0).
    runFrame(1, 8'h03, 8'b1100_0000, 1'b0, "lsb_03");
    // LSB first: 8E gives 0,1,1,1,0,0,0,1 (parity 0).
    runFrame(1, 8'h8E, 8'b0111_0001, 1'b0, "lsb_8e");

    // Gap of 3 with in_valid held high. The first word is 3C, and in_data is
    // changed to 81 while the first frame is still being sent. The second
    // word's first bit must appear 12+P cycles after the first word's.
    applyStimulus(2, 1'b1, 8'h3C);
    tick();
    applyStimulus(2, 1'b1, 8'h81);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] s;
      s = 8'b0011_1100;
      checkOutput($sformatf("gap_w1_bit%0d", i), sampleOut(2),
                  {1'b0, s[7-i], 1'b1, (i == 7 && P == 0), 1'b1});
      tick();
    end
    if (P == 1) begin
      checkOutput("gap_w1_parity", sampleOut(2), 5'b0_0_1_1_1);
      tick();
    end
    for (int g = 0; g < 3; g++) begin
      checkOutput($sformatf("gap_between%0d", g), sampleOut(2), 5'b0_0_0_0_1);
      tick();
    end
    checkOutput("gap_reaccept", sampleOut(2), 5'b1_0_0_0_0);
    tick();
    applyStimulus(2, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] s;
      s = 8'b1000_0001;
      checkOutput($sformatf("gap_w2_bit%0d", i), sampleOut(2),
                  {1'b0, s[7-i], 1'b1, (i == 7 && P == 0), 1'b1});
      tick();
    end
    if (P == 1) begin
      checkOutput("gap_w2_parity", sampleOut(2), 5'b0_0_1_1_1);
      tick();
    end
    for (int g = 0; g < 3; g++) begin
      checkOutput($sformatf("gap_tail%0d", g), sampleOut(2), 5'b0_0_0_0_1);
      tick();
    end
    checkOutput("gap_final_idle", sampleOut(2), 5'b1_0_0_0_0);

    // Reset in the middle of a frame: FF accepted at edge N, rst_n low at
    // edge N+4. The block must go idle and then send 01 cleanly.
    applyStimulus(0, 1'b1, 8'hFF);
    tick();
    applyStimulus(0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("midrst_bit%0d", i), sampleOut(0), 5'b0_1_1_0_1);
      tick();
    end
    rst_n = 1'b0;
    tick();
    checkOutput("midrst_idle", sampleOut(0), 5'b1_0_0_0_0);
    rst_n = 1'b1;
    tick();
    checkOutput("midrst_still_idle", sampleOut(0), 5'b1_0_0_0_0);
    runFrame(0, 8'h01, 8'b0000_0001, 1'b1, "post_rst_01");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_bit_serializer
